// File: rtl/aes128_key_expand.sv
// ============================================================================
//  Module      : aes128_key_expand
//  Description : Iterative AES-128 key schedule, one round key per handshake.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  assign y = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

module aes128_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t       state;
  logic [7:0]   rcon;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  w0_next;
  logic [31:0]  w1_next;
  logic [31:0]  w2_next;
  logic [31:0]  w3_next;
  logic [7:0]   rcon_next;

  assign rot_word = {rk_out[23:0], rk_out[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_word[8*b +: 8]),
      .y (sub_word[8*b +: 8])
    );
  end

  assign t_word    = sub_word ^ {rcon, 24'h0};
  assign w0_next   = rk_out[127:96] ^ t_word;
  assign w1_next   = rk_out[95:64]  ^ w0_next;
  assign w2_next   = rk_out[63:32]  ^ w1_next;
  assign w3_next   = rk_out[31:0]   ^ w2_next;
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rcon     <= 8'h01;
      rk_out   <= 128'h0;
      rk_idx   <= 4'h0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= GEN;
            rk_out   <= key_in;
            rk_idx   <= 4'h0;
            rcon     <= 8'h01;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
          end
        end
        GEN: begin
          if (rk_ready) begin
            if (rk_idx == LAST_IDX) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_out <= {w0_next, w1_next, w2_next, w3_next};
              rk_idx <= rk_idx + 4'h1;
              rcon   <= rcon_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_aes128_key_expand.sv
// ============================================================================
//  Module      : tb_aes128_key_expand
//  Description : Randomised self-checking bench for the AES-128 key schedule.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_aes128_key_expand;
  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_K1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_K10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] A1_K2   = 128'hf2c295f27a96b9435935807a7359f67f;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, rk_ready, busy, rk_valid, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;
  logic         start2, ready2, busy2, valid2, done2;
  logic [127:0] key2, out2;
  logic [3:0]   idx2;

  aes128_key_expand #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
  );

  aes128_key_expand #(.NR(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key_in(key2), .busy(busy2),
    .rk_valid(valid2), .rk_ready(ready2), .rk_out(out2), .rk_idx(idx2), .done(done2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] exp_rk [0:10];

  // Reference model: GF(2^8) arithmetic, S-box from inverse + affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic compute_ref(input logic [127:0] key, input int nr);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 4 * (nr + 1); i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_ref(temp[31:24]), sbox_ref(temp[23:16]),
                sbox_ref(temp[15:8]), sbox_ref(temp[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= nr; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    n_checks++; if ({rk_valid, busy, done, rk_idx, rk_out} !== '0) $display("FAIL reset_hold: got v=%b b=%b d=%b idx=%0d out=%h, want all 0", rk_valid, busy, done, rk_idx, rk_out); else n_pass++;
    #2 rst = 1'b0;
    tick();
    n_checks++; if ({rk_valid, busy, done, rk_idx, rk_out} !== '0) $display("FAIL reset_release: got v=%b b=%b d=%b idx=%0d out=%h, want all 0", rk_valid, busy, done, rk_idx, rk_out); else n_pass++;
    n_checks++; if ({valid2, busy2, done2} !== 3'b000) $display("FAIL reset_nr2: got %b, want 000", {valid2, busy2, done2}); else n_pass++;
  endtask

  task automatic test_fips_a1;
    compute_ref(KEY_A1, 10);
    key_in = KEY_A1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i <= 10; i++) begin
      n_checks++; if ({rk_valid, busy, done, rk_idx} !== {3'b110, 4'(i)}) $display("FAIL a1_ctrl[%0d]: got v=%b b=%b d=%b idx=%0d", i, rk_valid, busy, done, rk_idx); else n_pass++;
      n_checks++; if (rk_out !== exp_rk[i]) $display("FAIL a1_key[%0d]: got %h want %h", i, rk_out, exp_rk[i]); else n_pass++;
      if (i == 1) begin n_checks++; if (rk_out !== A1_K1) $display("FAIL a1_k1_vector: got %h want %h", rk_out, A1_K1); else n_pass++; end
      if (i == 10) begin n_checks++; if (rk_out !== A1_K10) $display("FAIL a1_k10_vector: got %h want %h", rk_out, A1_K10); else n_pass++; end
      tick();
    end
    n_checks++; if ({rk_valid, busy, done} !== 3'b001) $display("FAIL a1_done: got v/b/d=%b want 001", {rk_valid, busy, done}); else n_pass++;
    tick();
    n_checks++; if ({rk_valid, busy, done} !== 3'b000) $display("FAIL a1_done_pulse: got v/b/d=%b want 000", {rk_valid, busy, done}); else n_pass++;
  endtask

  task automatic test_backpressure;
    int exp_idx, stalled3, stalled10;
    bit finished;
    compute_ref(KEY_A1, 10);
    exp_idx = 0; stalled3 = 0; stalled10 = 0; finished = 1'b0;
    key_in = KEY_A1; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      n_checks++; if ({rk_valid, done, rk_idx} !== {2'b10, 4'(exp_idx)} || rk_out !== exp_rk[exp_idx]) $display("FAIL bp_state[cyc %0d]: got v=%b d=%b idx=%0d out=%h want idx=%0d out=%h", cyc, rk_valid, done, rk_idx, rk_out, exp_idx, exp_rk[exp_idx]); else n_pass++;
      if (exp_idx == 3 && stalled3 < 5) begin rk_ready = 1'b0; stalled3++; end
      else if (exp_idx == 10 && stalled10 < 5) begin rk_ready = 1'b0; stalled10++; end
      else rk_ready = 1'($urandom_range(0, 1));
      tick();
      if (rk_ready) begin
        if (exp_idx == 10) finished = 1'b1;
        else exp_idx++;
      end
    end
    n_checks++; if (!finished) $display("FAIL bp_timeout: reached idx %0d, want 10 accepted", exp_idx); else n_pass++;
    n_checks++; if ({rk_valid, busy, done} !== 3'b001) $display("FAIL bp_done: got v/b/d=%b want 001", {rk_valid, busy, done}); else n_pass++;
    rk_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    compute_ref(KEY_A1, 10);
    key_in = KEY_A1; start = 1'b1; rk_ready = 1'b1;
    tick();
    for (int i = 0; i <= 10; i++) begin
      start = (i == 4);
      key_in = (i == 4) ? 128'h0 : KEY_A1;
      n_checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_rk[i]) $display("FAIL busy_start[%0d]: got v=%b idx=%0d out=%h want %h", i, rk_valid, rk_idx, rk_out, exp_rk[i]); else n_pass++;
      tick();
    end
    n_checks++; if ({rk_valid, done} !== 2'b01) $display("FAIL busy_start_done: got v/d=%b want 01", {rk_valid, done}); else n_pass++;
    compute_ref(128'h0, 10);
    key_in = 128'h0; start = 1'b1;
    tick();
    start = 1'b0; key_in = KEY_A1;
    for (int i = 0; i <= 10; i++) begin
      n_checks++; if ({rk_valid, busy, rk_idx} !== {2'b11, 4'(i)} || rk_out !== exp_rk[i]) $display("FAIL zero_key[%0d]: got v=%b idx=%0d out=%h want %h", i, rk_valid, rk_idx, rk_out, exp_rk[i]); else n_pass++;
      if (i == 1) begin n_checks++; if (rk_out !== Z_K1) $display("FAIL zero_k1_vector: got %h want %h", rk_out, Z_K1); else n_pass++; end
      if (i == 10) begin n_checks++; if (rk_out !== Z_K10) $display("FAIL zero_k10_vector: got %h want %h", rk_out, Z_K10); else n_pass++; end
      tick();
    end
    n_checks++; if ({rk_valid, busy, done} !== 3'b001) $display("FAIL zero_done: got v/b/d=%b want 001", {rk_valid, busy, done}); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid;
    compute_ref(KEY_A1, 10);
    key_in = KEY_A1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (rk_idx !== 4'd6 || rk_out !== exp_rk[6]) $display("FAIL rst_mid_pre: got idx=%0d out=%h want idx=6", rk_idx, rk_out); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({rk_valid, busy, done} !== 3'b000) $display("FAIL rst_mid_async: got v/b/d=%b want 000", {rk_valid, busy, done}); else n_pass++;
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({rk_valid, busy, done} !== 3'b000) $display("FAIL rst_mid_quiet[%0d]: got v/b/d=%b want 000", i, {rk_valid, busy, done}); else n_pass++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({rk_valid, rk_idx} !== {1'b1, 4'd0} || rk_out !== KEY_A1) $display("FAIL rst_restart_k0: got v=%b idx=%0d out=%h", rk_valid, rk_idx, rk_out); else n_pass++;
    tick();
    n_checks++; if (rk_idx !== 4'd1 || rk_out !== A1_K1) $display("FAIL rst_restart_k1: got idx=%0d out=%h want %h", rk_idx, rk_out, A1_K1); else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if ({rk_valid, done} !== 2'b01) $display("FAIL rst_restart_done: got v/d=%b want 01", {rk_valid, done}); else n_pass++;
    tick();
  endtask

  task automatic test_nr2;
    compute_ref(KEY_A1, 2);
    key2 = KEY_A1; start2 = 1'b1; ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      n_checks++; if ({valid2, busy2, done2, idx2} !== {3'b110, 4'(i)} || out2 !== exp_rk[i]) $display("FAIL nr2_key[%0d]: got v=%b idx=%0d out=%h want %h", i, valid2, idx2, out2, exp_rk[i]); else n_pass++;
      if (i == 2) begin n_checks++; if (out2 !== A1_K2) $display("FAIL nr2_k2_vector: got %h want %h", out2, A1_K2); else n_pass++; end
      tick();
    end
    n_checks++; if ({valid2, busy2, done2} !== 3'b001) $display("FAIL nr2_done: got v/b/d=%b want 001", {valid2, busy2, done2}); else n_pass++;
    tick();
    n_checks++; if ({valid2, busy2, done2} !== 3'b000) $display("FAIL nr2_idle: got v/b/d=%b want 000", {valid2, busy2, done2}); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    start2 = 1'b0; ready2 = 1'b0; key2 = '0;
    test_reset();
    test_fips_a1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_nr2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
Iterative AES-128 key schedule (FIPS-197 §5.2) that produces round keys 0..NR, one per handshake, for the round pipeline downstream.
- SubWord is built from four sbox instances applied to RotWord(w3).
- It sits between the key-load interface and the AddRoundKey stages, which consume round keys through a valid/ready stream.

Parameters:
NR, 10, index of the last round key emitted; legal range 1..10; values below 10 truncate the standard schedule.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to load key_in; sampled only in IDLE.
key_in  input  128  cipher key; [127:96]=w0, [31:0]=w3, big-endian bytes.
busy  output  1  high from the cycle after an accepted start until the cycle after the last accept.
rk_valid  output  1  rk_out/rk_idx hold a valid round key.
rk_ready  input  1  downstream accepts the round key when rk_valid && rk_ready.
rk_out  output  128  current round key; same word/byte order as key_in.
rk_idx  output  4  round index of rk_out, 0..NR.
done  output  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset: asynchronous, active-high. While rst is high and after release, all outputs are 0, the FSM is in IDLE, the rcon register is 8'h01, and the key register is 0. Reset asserted mid-schedule aborts immediately; no done pulse.
- FSM has two states, IDLE and GEN.
- IDLE behaviour:
  - On start=1, key_in is captured into the key register, rk_idx is set to 0, and rcon is set to 01.
  - The next state is GEN. busy=1 and rk_valid=1 from the following cycle, so latency from start to the first rk_valid is 1 cycle.
- IDLE with start=0: nothing changes; rk_valid=0.
- GEN behaviour:
  - rk_valid=1 continuously; rk_out is the key register.
  - Without an accept (rk_ready=0), rk_out, rk_idx and rcon hold stable.
- GEN, accept with rk_idx < NR, the next round key is computed combinationally from the current register:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- This is registered in the same edge: rk_idx increments and rcon advances by xtime (rcon<<1, XOR 8'h1b if rcon[7] was set).
  - Rcon sequence: 01 02 04 08 10 20 40 80 1b 36.
  - Back-to-back accepts yield one round key per cycle.
- GEN, accept with rk_idx == NR:
  - Next state is IDLE; rk_valid=0, busy=0 and done=1, each for the following cycle only.
  - rk_out and rk_idx keep their last values while idle; they are don't-care when rk_valid=0, and the bench must not check them.
- start while busy (GEN) is ignored; it does not restart or corrupt the schedule.
- start in the same cycle that done is high is accepted, since the FSM is back in IDLE. A new schedule can therefore begin 1 cycle after done.
- key_in is sampled only on the accepting start edge; later changes have no effect.
- rk_ready is ignored while rk_valid=0.
- No combinational path from rk_ready to rk_valid or rk_out.
- The sbox path is purely combinational inside one cycle; there is no pipelining of SubWord.

Test Plan:
- FIPS-197 A.1 key:
  - Stimulus: start with key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready tied 1.
  - Required: idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required timing: 11 consecutive valid cycles, then done one cycle later.
- All-zero key:
  - Stimulus: start with key_in=0.
  - Required: idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Stimulus: A.1 key with rk_ready randomly toggled, including 5-cycle stalls at idx 3 and idx 10.
  - Required: rk_out and rk_idx stable during stalls; same 11 values as the first scenario; done only after the idx10 accept.
- start while busy:
  - Stimulus: pulse start with the zero key at idx 4 of an A.1 run.
  - Required: the A.1 sequence completes unaltered.
  - Then start with the zero key on the done cycle; required: idx0 = 0 appears on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges at idx 6.
  - Required: rk_valid, busy and done go to 0 immediately; no done pulse.
  - Then restart with the A.1 key; required: idx1 = a0fafe17… again, confirming rcon was reset to 01.
- NR=2 build:
  - Stimulus: A.1 key.
  - Required: exactly 3 round keys, idx2 = f2c295f27a96b9435935807a7359f67f, then done.
